// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Control bundle between the multicycle MIPS main control unit and its
// datapath.
//
//   opcode      IR[31:26], driven by the datapath; valid from DECODE onward
//   mem_ready   memory completes the current access this cycle
//   PCWrite     unconditional PC load
//   PCWriteCond PC load if ALU zero (beq)
//   IorD        memory address select   0=PC, 1=ALUOut
//   MemRead     memory read request
//   MemWrite    memory write request
//   IRWrite     load IR
//   MemtoReg    write-back select       0=ALUOut, 1=MDR
//   RegDst      destination register    0=rt, 1=rd
//   RegWrite    register file write
//   ALUSrcA     ALU A operand           0=PC, 1=A
//   ALUSrcB     ALU B operand           00=B, 01=4, 10=simm, 11=simm<<2
//   PCSource    PC source               00=ALU, 01=ALUOut, 10=jump addr
//   ALUOp       ALU operation           00=add, 01=sub, 10=funct
//
// master: the control unit (drives the selects/strobes).
// slave : the datapath (drives opcode and mem_ready).
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS main control unit. A Moore FSM that steps each instruction
// through FETCH / DECODE / execute / write-back and drives every datapath
// select and write-enable. The only Mealy terms are IRWrite/PCWrite in FETCH,
// which are gated by mem_ready so the IR and PC load only on the cycle the
// fetch actually completes.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (returns to INIT, clears count)
//   bus        control bundle (master side): opcode/mem_ready in, controls out
//   fetch_cnt  number of completed fetches, wraps modulo 2^CNT_W
//   state_o    current state code (debug)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
   parameter int CNT_W   = 32,
   parameter int STATE_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mc_ctrl_fsm_if.master       bus,
   output logic [CNT_W-1:0]    fetch_cnt,
   output logic [STATE_W-1:0]  state_o
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MADDR  = 4'd3,
      S_MRD    = 4'd4,
      S_MWB    = 4'd5,
      S_MWR    = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JMP    = 4'd10,
      S_IEX    = 4'd11,
      S_IWB    = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_e state, next_state;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= next_state;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: next_state gets a default before the case so every path assigns
   // it and no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         S_INIT:   next_state = S_FETCH;
         S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: next_state = S_MADDR;
               OP_RTYPE:     next_state = S_REX;
               OP_BEQ:       next_state = S_BEQ;
               OP_J:         next_state = S_JMP;
               OP_ADDI:      next_state = S_IEX;
               default:      next_state = S_FETCH;   // unsupported: dropped
            endcase
         end
         // IR holds the opcode, so it still tells lw from sw here.
         S_MADDR:  next_state = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
         S_MRD:    if (bus.mem_ready) next_state = S_MWB;
         S_MWB:    next_state = S_FETCH;
         S_MWR:    if (bus.mem_ready) next_state = S_FETCH;
         S_REX:    next_state = S_RWB;
         S_RWB:    next_state = S_FETCH;
         S_BEQ:    next_state = S_FETCH;
         S_JMP:    next_state = S_FETCH;
         S_IEX:    next_state = S_IWB;
         S_IWB:    next_state = S_FETCH;
         default:  next_state = S_INIT;               // unused codes recover
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic: everything defaults to 0, each state raises only its own
   // selects and strobes.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.PCSource    = 2'b00;
      bus.ALUOp       = 2'b00;
      unique case (state)
         S_FETCH: begin
            // PC+4 computed every cycle; IR and PC load only on completion.
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.mem_ready;
            bus.PCWrite = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;              // branch target into ALUOut
         end
         S_MADDR, S_IEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MRD: begin
            bus.IorD    = 1'b1;
            bus.MemRead = 1'b1;
         end
         S_MWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_MWR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_REX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 2'b10;
         end
         S_RWB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_BEQ: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = 2'b01;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
         end
         S_JMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         S_IWB: begin
            bus.RegWrite = 1'b1;
         end
         default: ;                           // INIT and unused codes: all 0
      endcase
   end

   // ------------------------------------------------------------------------
   // Retired-fetch counter: bumps on the cycle a fetch completes.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_cnt <= '0;
      else if (state == S_FETCH && bus.mem_ready)
         fetch_cnt <= fetch_cnt + CNT_W'(1);
   end

   assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Bench for mc_ctrl_fsm. Each stimulus cycle pushes the expected state code,
// control vector and fetch count onto a scoreboard queue; a negedge monitor
// pops and compares against the DUT. Scenario tasks add inline checks for
// asynchronous reset and counter wrap. The DUT uses CNT_W=4 so wrap is cheap.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

   localparam int TB_CNT_W = 4;

   localparam logic [3:0] ST_INIT   = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_DECODE = 4'd2;
   localparam logic [3:0] ST_MADDR  = 4'd3;
   localparam logic [3:0] ST_MRD    = 4'd4;
   localparam logic [3:0] ST_MWB    = 4'd5;
   localparam logic [3:0] ST_MWR    = 4'd6;
   localparam logic [3:0] ST_REX    = 4'd7;
   localparam logic [3:0] ST_RWB    = 4'd8;
   localparam logic [3:0] ST_BEQ    = 4'd9;
   localparam logic [3:0] ST_JMP    = 4'd10;
   localparam logic [3:0] ST_IEX    = 4'd11;
   localparam logic [3:0] ST_IWB    = 4'd12;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef struct {
      logic [3:0]          st;
      ctrl_t               ctrl;
      logic [TB_CNT_W-1:0] cnt;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic [TB_CNT_W-1:0] fetch_cnt;
   logic [3:0]          state_o;
   ctrl_t               act;

   int                  checks;
   int                  errors;
   exp_t                sb_q[$];
   exp_t                mon_e;
   logic                sb_en;
   logic [TB_CNT_W-1:0] exp_cnt;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(
      .CNT_W   (TB_CNT_W),
      .STATE_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.master),
      .fetch_cnt (fetch_cnt),
      .state_o   (state_o)
   );

   assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                 bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource,
                 bus.ALUOp};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Reference control table, written straight from the state descriptions.
   function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic mr);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            c.ir_write = mr;   c.pc_write  = mr;
         end
         ST_DECODE: c.alu_src_b = 2'b11;
         ST_MADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         ST_MRD:    begin c.iord = 1'b1; c.mem_read = 1'b1; end
         ST_MWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         ST_MWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
         ST_REX:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         ST_RWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         ST_BEQ: begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01;
            c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
         end
         ST_JMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         ST_IEX:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         ST_IWB:    c.reg_write = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   // Scoreboard monitor: samples mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (sb_en) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: no expectation queued at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            checks++;
            if (state_o !== mon_e.st || act !== mon_e.ctrl || fetch_cnt !== mon_e.cnt) begin
               errors++;
               $display("FAIL cycle@%0t: got state=%0d ctrl=%h cnt=%0d, expected state=%0d ctrl=%h cnt=%0d",
                        $time, state_o, act, fetch_cnt, mon_e.st, mon_e.ctrl, mon_e.cnt);
            end
            checks++;
            if (((bus.MemRead & bus.MemWrite) | (bus.RegWrite & bus.MemWrite)) !== 1'b0) begin
               errors++;
               $display("FAIL mutex@%0t: MemRead=%b MemWrite=%b RegWrite=%b, expected no overlap",
                        $time, bus.MemRead, bus.MemWrite, bus.RegWrite);
            end
         end
      end
   end

   // One clock of stimulus: called at posedge+1, queues this cycle's
   // expectation, then advances to the next posedge+1.
   task automatic cyc(input logic [3:0] s, input logic mr);
      exp_t e;
      bus.mem_ready = mr;
      e.st   = s;
      e.ctrl = exp_ctrl(s, mr);
      e.cnt  = exp_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (s == ST_FETCH && mr) exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic do_reset();
      sb_en  = 1'b0;
      rst_n  = 1'b0;
      #1;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_cnt = '0;
      sb_en   = 1'b1;
      cyc(ST_INIT, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      bus.opcode = OP_R;
      exp_cnt = '0;
      sb_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (state_o !== ST_INIT) begin
         errors++;
         $display("FAIL reset_state: got %0d, expected %0d", state_o, ST_INIT);
      end
      checks++;
      if (act !== ctrl_t'(0)) begin
         errors++;
         $display("FAIL reset_ctrl: got %h, expected 0", act);
      end
      checks++;
      if (fetch_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d, expected 0", fetch_cnt);
      end
      rst_n = 1'b1;
      sb_en = 1'b1;
      cyc(ST_INIT, 1'b1);
   endtask

   // R-type; mem_ready held low outside FETCH to show it is ignored there.
   task automatic test_rtype();
      bus.opcode = OP_R;
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b0);
      cyc(ST_REX,    1'b0);
      cyc(ST_RWB,    1'b0);
   endtask

   task automatic test_lw_wait();
      bus.opcode = OP_LW;
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      cyc(ST_MADDR,  1'b0);
      repeat (3) cyc(ST_MRD, 1'b0);
      cyc(ST_MRD,    1'b1);
      cyc(ST_MWB,    1'b0);
   endtask

   task automatic test_sw_fetch_wait();
      bus.opcode = OP_SW;
      repeat (2) cyc(ST_FETCH, 1'b0);
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      cyc(ST_MADDR,  1'b1);
      cyc(ST_MWR,    1'b0);
      cyc(ST_MWR,    1'b1);
   endtask

   task automatic test_addi();
      bus.opcode = OP_ADDI;
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b0);
      cyc(ST_IEX,    1'b1);
      cyc(ST_IWB,    1'b0);
   endtask

   task automatic test_back_to_back();
      logic [TB_CNT_W-1:0] start_cnt;
      start_cnt = fetch_cnt;
      bus.opcode = OP_BEQ;
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      bus.opcode = OP_J;
      cyc(ST_BEQ,    1'b1);
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      cyc(ST_JMP,    1'b1);
      checks++;
      if (fetch_cnt !== TB_CNT_W'(start_cnt + 2)) begin
         errors++;
         $display("FAIL b2b_cnt: got %0d, expected %0d", fetch_cnt, TB_CNT_W'(start_cnt + 2));
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ill [3];
      ill[0] = 6'b111111;
      ill[1] = 6'b000011;
      ill[2] = 6'b100000;
      for (int i = 0; i < 3; i++) begin
         bus.opcode = ill[i];
         cyc(ST_FETCH,  1'b1);
         cyc(ST_DECODE, 1'b1);
      end
   endtask

   task automatic test_reset_mid_access();
      bus.opcode = OP_LW;
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      cyc(ST_MADDR,  1'b1);
      cyc(ST_MRD,    1'b0);
      // Now inside the second MRD cycle; assert reset between clock edges.
      sb_en = 1'b0;
      bus.mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state_o !== ST_INIT) begin
         errors++;
         $display("FAIL async_rst_state: got %0d, expected %0d", state_o, ST_INIT);
      end
      checks++;
      if (act !== ctrl_t'(0)) begin
         errors++;
         $display("FAIL async_rst_ctrl: got %h, expected 0", act);
      end
      checks++;
      if (fetch_cnt !== '0) begin
         errors++;
         $display("FAIL async_rst_cnt: got %0d, expected 0", fetch_cnt);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_cnt = '0;
      sb_en   = 1'b1;
      cyc(ST_INIT,   1'b1);
      cyc(ST_FETCH,  1'b1);
      cyc(ST_DECODE, 1'b1);
      cyc(ST_MADDR,  1'b1);
      cyc(ST_MRD,    1'b1);
      cyc(ST_MWB,    1'b1);
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      bus.opcode = OP_J;
      for (int i = 0; i < 15; i++) begin
         cyc(ST_FETCH,  1'b1);
         cyc(ST_DECODE, 1'b1);
         cyc(ST_JMP,    1'b1);
      end
      checks++;
      if (fetch_cnt !== 4'd15) begin
         errors++;
         $display("FAIL cnt_max: got %0d, expected 15", fetch_cnt);
      end
      cyc(ST_FETCH, 1'b1);
      checks++;
      if (fetch_cnt !== 4'd0) begin
         errors++;
         $display("FAIL cnt_wrap: got %0d, expected 0", fetch_cnt);
      end
      cyc(ST_DECODE, 1'b1);
      cyc(ST_JMP,    1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw_fetch_wait();
      test_addi();
      test_back_to_back();
      test_illegal();
      test_reset_mid_access();
      test_cnt_wrap();
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
